// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Flow-controlled pipeline stage register that carries one control vector
// and one data vector per beat under a valid/ready handshake.  It supports
// stall (backpressure), flush (bubble insertion) and an optional one-entry
// skid buffer that removes the combinational out_ready -> in_ready path.
//
// A bubble (out_valid=0) always presents an all-zero control vector, so a
// downstream stage never sees a stray register or memory write enable.
//
// Parameters
//   DATA_W  width of the data payload
//   CTRL_W  width of the control payload
//   SKID    0: single register, in_ready depends combinationally on out_ready
//           1: main register plus one skid entry, in_ready independent of
//              out_ready
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (highest priority)
//   flush      synchronous squash of every held beat (second priority)
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_ctrl    upstream control vector
//   in_data    upstream data vector
//   out_valid  downstream beat present
//   out_ready  downstream accepts this cycle
//   out_ctrl   held control vector, all-zero whenever out_valid=0
//   out_data   held data vector (holds its last value during bubbles)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 3,
   parameter bit SKID   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   // Main (output) register, common to both variants.  The control field is
   // kept at zero whenever the valid bit is clear, so the outputs can be
   // driven straight from the registers with no masking logic.
   logic              mainValidReg;
   logic [CTRL_W-1:0] mainCtrlReg;
   logic [DATA_W-1:0] mainDataReg;

   // The main register is free when it is empty or its beat leaves this cycle.
   logic mainFree;
   assign mainFree = !mainValidReg || out_ready;

   assign out_valid = mainValidReg;
   assign out_ctrl  = mainCtrlReg;
   assign out_data  = mainDataReg;

   generate
      if (SKID == 1'b0) begin : gDirect
         // -------------------------------------------------------------
         // Single register.  Ready follows the downstream ready through
         // combinational logic, which is the cheapest option but chains
         // the ready path across stages.
         // -------------------------------------------------------------
         logic inReadyComb;
         assign inReadyComb = !flush && mainFree;
         assign in_ready    = inReadyComb;

         always_ff @(posedge clk) begin
            if (reset) begin
               mainValidReg <= 1'b0;
               mainCtrlReg  <= '0;
               mainDataReg  <= '0;
            end else if (flush) begin
               // Squash the held beat; data is left alone since it is a
               // don't-care while out_valid is low.
               mainValidReg <= 1'b0;
               mainCtrlReg  <= '0;
            end else if (inReadyComb) begin
               mainValidReg <= in_valid;
               if (in_valid) begin
                  mainCtrlReg <= in_ctrl;
                  mainDataReg <= in_data;
               end else begin
                  mainCtrlReg <= '0;
               end
            end
         end
      end else begin : gSkid
         // -------------------------------------------------------------
         // Main register plus a one-entry skid buffer.  in_ready is a
         // function of local state and flush only, so the ready path is
         // broken at this stage.  When the downstream stalls with the
         // main register full, the beat accepted in that same cycle (the
         // upstream could not yet see the stall) lands in the skid entry.
         // -------------------------------------------------------------
         logic              skidValidReg;
         logic [CTRL_W-1:0] skidCtrlReg;
         logic [DATA_W-1:0] skidDataReg;

         logic inReadyComb;
         logic accept;

         assign inReadyComb = !skidValidReg && !flush;
         assign in_ready    = inReadyComb;
         assign accept      = in_valid && inReadyComb;

         always_ff @(posedge clk) begin
            if (reset) begin
               mainValidReg <= 1'b0;
               mainCtrlReg  <= '0;
               mainDataReg  <= '0;
               skidValidReg <= 1'b0;
               skidCtrlReg  <= '0;
               skidDataReg  <= '0;
            end else if (flush) begin
               mainValidReg <= 1'b0;
               mainCtrlReg  <= '0;
               skidValidReg <= 1'b0;
               skidCtrlReg  <= '0;
               skidDataReg  <= '0;
            end else if (mainFree) begin
               if (skidValidReg) begin
                  // The skid beat is older than anything upstream, so it
                  // moves up first.  No accept can coincide with this
                  // because in_ready is low while the skid is occupied.
                  mainValidReg <= 1'b1;
                  mainCtrlReg  <= skidCtrlReg;
                  mainDataReg  <= skidDataReg;
                  skidValidReg <= 1'b0;
                  skidCtrlReg  <= '0;
               end else if (accept) begin
                  mainValidReg <= 1'b1;
                  mainCtrlReg  <= in_ctrl;
                  mainDataReg  <= in_data;
               end else begin
                  mainValidReg <= 1'b0;
                  mainCtrlReg  <= '0;
               end
            end else if (accept) begin
               // Main is full and stalled: park the new beat in the skid.
               skidValidReg <= 1'b1;
               skidCtrlReg  <= in_ctrl;
               skidDataReg  <= in_data;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Four instances share one stimulus stream:
//   0: DATA_W=69 SKID=0   1: DATA_W=69 SKID=1
//   2: DATA_W=8  SKID=0   3: DATA_W=8  SKID=1
// Directed vectors check instances 0 and 1 against hand-computed values; a
// per-instance FIFO scoreboard runs every cycle on all four instances.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        inValid;
   logic        outReady;
   logic [2:0]  inCtrl;
   logic [68:0] inData;

   logic        ir [4];
   logic        ov [4];
   logic [2:0]  oc [4];
   logic [68:0] od [4];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gDut
         localparam int DW = (gi < 2) ? 69 : 8;
         logic          irL;
         logic          ovL;
         logic [2:0]    ocL;
         logic [DW-1:0] odL;

         pipe_stage_reg #(
            .DATA_W (DW),
            .CTRL_W (3),
            .SKID   (gi % 2 == 1)
         ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (inValid),
            .in_ready  (irL),
            .in_ctrl   (inCtrl),
            .in_data   (inData[DW-1:0]),
            .out_valid (ovL),
            .out_ready (outReady),
            .out_ctrl  (ocL),
            .out_data  (odL)
         );

         assign ir[gi] = irL;
         assign ov[gi] = ovL;
         assign oc[gi] = ocL;
         assign od[gi] = 69'(odL);
      end
   endgenerate

   task automatic checkVal(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Scoreboard: one FIFO of {ctrl,data} per instance.  At each negedge the
   // current outputs are checked against the model, then this cycle's
   // handshake events are applied so the model matches the state after the
   // coming rising edge.
   // ---------------------------------------------------------------------
   logic [71:0] mq [4][4];
   int          cnt   [4] = '{default: 0};
   int          emits [4] = '{default: 0};
   bit          armed [4] = '{default: 1'b0};

   always @(negedge clk) begin
      logic        expReady;
      logic [68:0] mask;
      for (int i = 0; i < 4; i++) begin
         mask = (i < 2) ? {69{1'b1}} : 69'hFF;
         if (armed[i]) begin
            if (i % 2 == 0)
               expReady = !flush && (cnt[i] == 0 || outReady);
            else
               expReady = !flush && (cnt[i] < 2);
            checkVal("sb_valid", 72'(ov[i]), 72'(cnt[i] != 0));
            checkVal("sb_ready", 72'(ir[i]), 72'(expReady));
            if (!ov[i]) begin
               checkVal("sb_bubble_ctrl", 72'(oc[i]), 72'(0));
            end else if (cnt[i] != 0) begin
               checkVal("sb_ctrl", 72'(oc[i]), 72'(mq[i][0][71:69]));
               checkVal("sb_data", 72'(od[i]), 72'(mq[i][0][68:0]));
            end
         end
         if (reset) begin
            cnt[i]   = 0;
            armed[i] = 1'b1;
         end else if (armed[i]) begin
            if (ov[i] && outReady && cnt[i] != 0) begin
               for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
               cnt[i]--;
               emits[i]++;
            end
            if (flush) begin
               cnt[i] = 0;
            end else if (inValid && ir[i] && cnt[i] < 4) begin
               mq[i][cnt[i]] = {inCtrl, inData & mask};
               cnt[i]++;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed vectors followed by random traffic.
   // ---------------------------------------------------------------------
   initial begin
      // Reset held two cycles while upstream offers a beat.
      reset    = 1'b1;
      flush    = 1'b0;
      inValid  = 1'b1;
      inCtrl   = 3'b111;
      inData   = {69{1'b1}};
      outReady = 1'b1;
      step();
      step();
      for (int i = 0; i < 2; i++) begin
         checkVal("rst_valid", 72'(ov[i]), 72'(0));
         checkVal("rst_ctrl",  72'(oc[i]), 72'(0));
         checkVal("rst_data",  72'(od[i]), 72'(0));
      end
      reset   = 1'b0;
      inValid = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) checkVal("rst_ready", 72'(ir[i]), 72'(1));

      // Streaming: 8 back-to-back beats, each visible one cycle later.
      inCtrl = 3'b101;
      for (int k = 1; k <= 8; k++) begin
         inValid = 1'b1;
         inData  = 69'(k);
         step();
         for (int i = 0; i < 2; i++) begin
            checkVal("stream_valid", 72'(ov[i]), 72'(1));
            checkVal("stream_data",  72'(od[i]), 72'(k));
            checkVal("stream_ctrl",  72'(oc[i]), 72'(3'b101));
         end
      end
      inValid = 1'b0;
      step();
      for (int i = 0; i < 2; i++) checkVal("stream_end", 72'(ov[i]), 72'(0));

      // Stall: 0xA5 held for 4 cycles; SKID=1 also takes 0xB6 into the skid.
      inValid = 1'b1;
      inData  = 69'hA5;
      step();
      outReady = 1'b0;
      inData   = 69'hB6;
      #1;
      checkVal("stall_ready0", 72'(ir[0]), 72'(0));
      checkVal("stall_ready1", 72'(ir[1]), 72'(1));
      step();
      inValid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 2; i++) begin
            checkVal("stall_data",  72'(od[i]), 72'(8'hA5));
            checkVal("stall_valid", 72'(ov[i]), 72'(1));
            checkVal("stall_ready", 72'(ir[i]), 72'(0));
         end
         step();
      end
      outReady = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) checkVal("release_a5", 72'(od[i]), 72'(8'hA5));
      step();
      checkVal("release_d0_empty", 72'(ov[0]), 72'(0));
      checkVal("release_d1_valid", 72'(ov[1]), 72'(1));
      checkVal("release_d1_b6",    72'(od[1]), 72'(8'hB6));
      step();
      checkVal("release_d1_empty", 72'(ov[1]), 72'(0));

      // Flush with two beats held in the SKID=1 instance.
      outReady = 1'b0;
      inValid  = 1'b1;
      inData   = 69'h11;
      step();
      inData = 69'h22;
      step();
      flush  = 1'b1;
      inData = 69'hC7;
      #1;
      for (int i = 0; i < 2; i++) checkVal("flush_ready", 72'(ir[i]), 72'(0));
      step();
      flush   = 1'b0;
      inValid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checkVal("flush_valid", 72'(ov[i]), 72'(0));
         checkVal("flush_ctrl",  72'(oc[i]), 72'(0));
      end
      outReady = 1'b1;
      inValid  = 1'b1;
      inData   = 69'h33;
      step();
      inValid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checkVal("post_flush_valid", 72'(ov[i]), 72'(1));
         checkVal("post_flush_data",  72'(od[i]), 72'(8'h33));
      end
      step();

      // Bubble: in_valid 1,0,1 with ctrl 111 gives out_ctrl 111,000,111.
      inCtrl = 3'b111;
      inData = 69'h44;
      for (int k = 0; k < 3; k++) begin
         inValid = (k != 1);
         step();
         for (int i = 0; i < 2; i++) begin
            checkVal("bubble_valid", 72'(ov[i]), 72'(k != 1));
            checkVal("bubble_ctrl",  72'(oc[i]), 72'((k != 1) ? 3'b111 : 3'b000));
         end
      end
      inValid = 1'b0;
      step();

      // Reset together with flush in the middle of a stall.
      outReady = 1'b0;
      inValid  = 1'b1;
      inData   = 69'h55;
      step();
      inData = 69'h66;
      step();
      reset   = 1'b1;
      flush   = 1'b1;
      inValid = 1'b0;
      step();
      reset = 1'b0;
      flush = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checkVal("rstflush_valid", 72'(ov[i]), 72'(0));
         checkVal("rstflush_ctrl",  72'(oc[i]), 72'(0));
         checkVal("rstflush_data",  72'(od[i]), 72'(0));
         checkVal("rstflush_ready", 72'(ir[i]), 72'(1));
      end
      outReady = 1'b1;
      step();

      // Random traffic; the scoreboard does the checking.
      for (int i = 0; i < 4; i++) emits[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         inValid  = ($urandom_range(0, 3) != 0);
         outReady = ($urandom_range(0, 3) != 0) || (c % 1000 > 800);
         flush    = ($urandom_range(0, 31) == 0);
         reset    = ($urandom_range(0, 999) == 0);
         inCtrl   = 3'($urandom);
         inData   = {5'($urandom), $urandom, $urandom};
         step();
      end
      reset    = 1'b0;
      flush    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      step();
      step();
      for (int i = 0; i < 4; i++) checkVal("rand_progress", 72'(emits[i] > 1000), 72'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, flow-controlled pipeline stage register; the next generation of the fixed-width stage latches between EX/MEM and neighbouring stages.
- Carries one control vector and one data vector per beat under a valid/ready handshake.
- Supports stall (backpressure), flush (bubble insertion) and an optional skid buffer that breaks the combinational ready path.
- A bubble always presents an all-zero control vector (no register write, no memory write).

Parameters:
- DATA_W, 69, width of the data payload (e.g. ALU result 32 + store data 32 + write-register 5).
- CTRL_W, 3, width of the control payload (e.g. RegWrite, MemtoReg, MemWrite).
- SKID, 0, 0 = single register with a combinational ready path; 1 = main plus one-entry skid register with a registered in_ready.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_ctrl  input  CTRL_W  upstream control vector.
- in_data  input  DATA_W  upstream data vector.
- out_valid  output  1  downstream beat present.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  held control vector; all-zero whenever out_valid=0.
- out_data  output  DATA_W  held data vector.

Behaviour:
- One clock domain. All state updates on the rising edge of clk. Reset has highest priority, flush second.
- Reset (reset=1 at an edge) forces:
  - out_valid=0, out_ctrl=0, out_data=0.
  - Skid entry empty, skid contents zeroed.
  - in_ready=1 from the first cycle after reset deasserts.
- Handshake:
  - Accept occurs when in_valid&&in_ready.
  - Emit occurs when out_valid&&out_ready.
  - Latency: an accepted beat appears on out_* the next cycle. Throughput is 1 beat/cycle sustained in both modes.
- Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data hold bit-exact. out_valid never drops without an emit, except on flush or reset.
- Bubble: whenever out_valid=0, out_ctrl=0. out_data holds its last value (don't-care to downstream).
- SKID=0:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - On an edge with in_ready=1: out_valid<=in_valid; out_ctrl/out_data load from input when in_valid=1; out_ctrl<=0 when in_valid=0.
- SKID=1:
  - in_ready = !skid_valid && !flush, with no combinational dependence on out_ready.
  - Main empty, or main emitting: accepted beat goes to main, unless skid_valid, in which case skid moves to main.
  - Main full and not emitting: accepted beat goes to skid (skid_valid<=1).
  - When main emits and skid_valid=1: skid→main, skid_valid<=0. A beat accepted that same cycle is impossible, because in_ready=0.
  - Ordering is strictly FIFO. No beat is lost or duplicated.
- Flush (flush=1, reset=0):
  - The next cycle has out_valid=0, out_ctrl=0 and the skid emptied.
  - in_ready=0 during the flush cycle, so no beat is accepted.
  - An emit in the flush cycle still counts as delivered downstream.
- Simultaneous reset and flush: reset wins. The result is identical apart from out_data being zeroed.
- Reset asserted mid-stall: all held beats are discarded; no out_valid in the following cycle.

Test Plan:
- Reset: reset=1 for 2 cycles with in_valid=1, in_ctrl=3'b111 → out_valid=0, out_ctrl=0, out_data=0. First cycle after release: in_ready=1.
- Streaming: out_ready=1, 8 beats with in_data=1..8 and in_ctrl=3'b101 on consecutive cycles → out_data=1..8 each one cycle later, out_valid continuously 1. Repeat with SKID=1.
- Stall: beat data=0xA5 accepted, then out_ready=0 for 4 cycles → out_data=0xA5 stable. SKID=0: in_ready=0. SKID=1: beat 0xB6 accepted into skid, then in_ready=0. Release out_ready → 0xA5 then 0xB6 emitted in order.
- Flush: two beats held (SKID=1), flush=1 for 1 cycle with in_valid=1, in_data=0xC7 → next cycle out_valid=0, out_ctrl=0. 0xC7 is never emitted; the next offered beat passes normally.
- Bubble: in_valid toggles 1,0,1 with in_ctrl=3'b111 and out_ready=1 → out_ctrl sequence 111,000,111, with out_valid matching 1,0,1.
- Random: random in_valid/out_ready/flush over 10k cycles, both SKID values, DATA_W=8 and DATA_W=69 → a scoreboard shows order preserved, no loss except flushed beats, and out_ctrl=0 whenever out_valid=0.
